// File: rtl/robot_maze_world.sv
// robot_maze_world: grid-maze environment for the wall-following robot.
// Holds the loadable wall map, robot pose, bump pulse, sticky goal flag and a
// saturating command counter; sensors are decoded combinationally from state.
module robot_maze_world #(
   parameter int W         = 4,
   parameter int H         = 4,
   parameter int START_X   = 0,
   parameter int START_Y   = 0,
   parameter int START_DIR = 0,
   parameter int GOAL_X    = 3,
   parameter int GOAL_Y    = 3,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  map_we,
   input  logic [$clog2(W)-1:0]  map_x,
   input  logic [$clog2(H)-1:0]  map_y,
   input  logic [3:0]            map_walls,
   input  logic                  front,
   input  logic                  turn,
   output logic                  front_sensor,
   output logic                  left_sensor,
   output logic [$clog2(W)-1:0]  pos_x,
   output logic [$clog2(H)-1:0]  pos_y,
   output logic [1:0]            heading,
   output logic                  bump,
   output logic                  at_goal,
   output logic [CNT_W-1:0]      step_count
);

   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);
   localparam logic START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

   // Cell (x,y) lives at index y*W + x; bit d is the wall on side d (0=N..3=W).
   logic [3:0]       map_q [W*H];

   logic [XW-1:0]    pos_x_q, pos_x_d;
   logic [YW-1:0]    pos_y_q, pos_y_d;
   logic [1:0]       heading_q, heading_d;
   logic             bump_q, bump_d;
   logic             at_goal_q, at_goal_d;
   logic [CNT_W-1:0] step_q, step_d;

   logic             wr_hit;
   logic [3:0]       cur_walls;
   logic [3:0]       bnd_walls;
   logic [3:0]       wall_vec;

   // Out-of-range coordinates (possible when W or H is not a power of two) are dropped.
   assign wr_hit = map_we && (int'(map_x) < W) && (int'(map_y) < H);

   for (genvar gi = 0; gi < W*H; gi++) begin : g_cell
      logic wr_sel;
      assign wr_sel = wr_hit && (map_x == XW'(gi % W)) && (map_y == YW'(gi / W));

      // Per-cell wall register; cleared by reset so the maze starts empty.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            map_q[gi] <= '0;
         end else if (wr_sel) begin
            map_q[gi] <= map_walls;
         end
      end
   end

   // Select the wall bits of the cell the robot currently occupies.
   always_comb begin
      cur_walls = '0;
      for (int i = 0; i < W*H; i++) begin
         if ((pos_x_q == XW'(i % W)) && (pos_y_q == YW'(i / W))) begin
            cur_walls = map_q[i];
         end
      end
   end

   // The grid edge always acts as a wall regardless of the loaded map.
   assign bnd_walls[0] = (pos_y_q == YW'(H - 1));
   assign bnd_walls[1] = (pos_x_q == XW'(W - 1));
   assign bnd_walls[2] = (pos_y_q == '0);
   assign bnd_walls[3] = (pos_x_q == '0);
   assign wall_vec     = cur_walls | bnd_walls;

   // Left of heading h is (h+3)%4, which 2-bit wraparound gives as h-1.
   assign front_sensor = wall_vec[heading_q];
   assign left_sensor  = wall_vec[heading_q - 2'd1];

   // Next pose: turn wins over front; a blocked front only raises bump.
   always_comb begin
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      heading_d = heading_q;
      bump_d    = 1'b0;
      if (turn) begin
         heading_d = heading_q + 2'd1;
      end else if (front) begin
         if (wall_vec[heading_q]) begin
            bump_d = 1'b1;
         end else begin
            case (heading_q)
               2'd0:    pos_y_d = pos_y_q + YW'(1);
               2'd1:    pos_x_d = pos_x_q + XW'(1);
               2'd2:    pos_y_d = pos_y_q - YW'(1);
               default: pos_x_d = pos_x_q - XW'(1);
            endcase
         end
      end
      step_d    = ((front || turn) && (step_q != '1)) ? step_q + CNT_W'(1) : step_q;
      at_goal_d = at_goal_q || ((pos_x_d == XW'(GOAL_X)) && (pos_y_d == YW'(GOAL_Y)));
   end

   // Robot state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x_q   <= XW'(START_X);
         pos_y_q   <= YW'(START_Y);
         heading_q <= 2'(START_DIR);
         bump_q    <= 1'b0;
         at_goal_q <= START_AT_GOAL;
         step_q    <= '0;
      end else begin
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         heading_q <= heading_d;
         bump_q    <= bump_d;
         at_goal_q <= at_goal_d;
         step_q    <= step_d;
      end
   end

   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign heading    = heading_q;
   assign bump       = bump_q;
   assign at_goal    = at_goal_q;
   assign step_count = step_q;

endmodule

// File: tb/tb_robot_maze_world.sv
// Bench for robot_maze_world: directed scenarios plus a randomized
// sensor-driven run, all checked against a cell/neighbour reference model.
module tb_robot_maze_world;

   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        map_we = 1'b0;
   logic [1:0]  map_x = '0;
   logic [1:0]  map_y = '0;
   logic [3:0]  map_walls = '0;
   logic        front = 1'b0;
   logic        turn = 1'b0;
   logic        front_sensor, left_sensor, bump, at_goal;
   logic [1:0]  pos_x, pos_y, heading;
   logic [15:0] step_count;

   // Small 3x3 instance: exercises out-of-range writes and counter saturation.
   logic        s_we = 1'b0;
   logic [1:0]  s_x = '0;
   logic [1:0]  s_y = '0;
   logic [3:0]  s_walls = '0;
   logic        s_front = 1'b0;
   logic        s_turn = 1'b0;
   logic        s_fs, s_ls, s_bump, s_goal;
   logic [1:0]  s_px, s_py, s_hdg;
   logic [2:0]  s_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: pose, map[x][y], counters.
   int       m_x, m_y, m_h, m_step;
   bit       m_bump, m_goal;
   bit [3:0] m_map [W][H];
   int       dxt [4] = '{0, 1, 0, -1};
   int       dyt [4] = '{1, 0, -1, 0};

   robot_maze_world dut (
      .clk(clk), .rst_n(rst_n), .map_we(map_we), .map_x(map_x), .map_y(map_y),
      .map_walls(map_walls), .front(front), .turn(turn),
      .front_sensor(front_sensor), .left_sensor(left_sensor), .pos_x(pos_x),
      .pos_y(pos_y), .heading(heading), .bump(bump), .at_goal(at_goal),
      .step_count(step_count)
   );

   robot_maze_world #(.W(3), .H(3), .START_X(0), .START_Y(0), .START_DIR(1),
                      .GOAL_X(2), .GOAL_Y(2), .CNT_W(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .map_we(s_we), .map_x(s_x), .map_y(s_y),
      .map_walls(s_walls), .front(s_front), .turn(s_turn),
      .front_sensor(s_fs), .left_sensor(s_ls), .pos_x(s_px), .pos_y(s_py),
      .heading(s_hdg), .bump(s_bump), .at_goal(s_goal), .step_count(s_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A side is walled if the map says so or the neighbour lies off the grid.
   function automatic bit m_wall(input int x, input int y, input int d);
      int nx = x + dxt[d];
      int ny = y + dyt[d];
      return m_map[x][y][d] || nx < 0 || nx >= W || ny < 0 || ny >= H;
   endfunction

   function automatic void m_reset();
      m_x = 0; m_y = 0; m_h = 0; m_step = 0; m_bump = 0; m_goal = 0;
      foreach (m_map[i, j]) m_map[i][j] = '0;
   endfunction

   function automatic void m_step_fn(input bit f, input bit t, input bit we,
                                     input int wx, input int wy, input bit [3:0] ww);
      m_bump = 0;
      if (t) m_h = (m_h + 1) % 4;
      else if (f) begin
         if (m_wall(m_x, m_y, m_h)) m_bump = 1;
         else begin
            m_x += dxt[m_h];
            m_y += dyt[m_h];
         end
      end
      if ((f || t) && m_step < 65535) m_step++;
      if (m_x == 3 && m_y == 3) m_goal = 1;
      if (we && wx < W && wy < H) m_map[wx][wy] = ww;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".pos_x"}, pos_x, m_x);
      chk({tag, ".pos_y"}, pos_y, m_y);
      chk({tag, ".heading"}, heading, m_h);
      chk({tag, ".bump"}, bump, m_bump);
      chk({tag, ".at_goal"}, at_goal, m_goal);
      chk({tag, ".steps"}, step_count, m_step);
      chk({tag, ".front_sensor"}, front_sensor, m_wall(m_x, m_y, m_h));
      chk({tag, ".left_sensor"}, left_sensor, m_wall(m_x, m_y, (m_h + 3) % 4));
   endtask

   // One clock: drive inputs, advance model on the edge, compare 1 ns later.
   task automatic step(input string tag, input bit f, input bit t, input bit we = 0,
                       input int wx = 0, input int wy = 0, input bit [3:0] ww = 0);
      front = f; turn = t; map_we = we;
      map_x = 2'(wx); map_y = 2'(wy); map_walls = ww;
      @(posedge clk);
      m_step_fn(f, t, we, wx, wy, ww);
      #1;
      front = 0; turn = 0; map_we = 0;
      check_all(tag);
      $display("step %s: f=%0b t=%0b we=%0b pos=(%0d,%0d) hdg=%0d bump=%0b goal=%0b cnt=%0d",
               tag, f, t, we, pos_x, pos_y, heading, bump, at_goal, step_count);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 0;
      @(posedge clk);
      #1 rst_n = 1;
      m_reset();
   endtask

   initial begin
      m_reset();
      do_reset();
      // Reset state on the empty maze
      check_all("reset");

      // Drive north to the boundary, then bump
      step("north1", 1, 0);
      step("north2", 1, 0);
      step("north3", 1, 0);
      chk("north3.fs_literal", front_sensor, 1);
      step("bump", 1, 0);
      chk("bump.literal", bump, 1);
      chk("bump.cnt_literal", step_count, 4);
      step("bump_clear", 0, 0);

      // Full rotation, then the south-facing sensor view at the origin
      for (int i = 0; i < 4; i++) step("rot", 0, 1);
      chk("rot.back_to_n", heading, 0);
      do_reset();
      step("to_e", 0, 1);
      step("to_s", 0, 1);
      chk("s.front_literal", front_sensor, 1);
      chk("s.left_literal", left_sensor, 0);
      step("both_cmd", 1, 1);

      // Map writes: same-edge move uses the old map; new wall visible after edge
      do_reset();
      step("wr_move", 1, 0, 1, 0, 0, 4'b0001);
      step("wr_east", 0, 0, 1, 0, 0, 4'b0010);
      step("back_s", 0, 1);
      step("back_s2", 0, 1);
      step("ret", 1, 0);
      step("face_w", 0, 1);
      step("face_n", 0, 1);
      step("face_e", 0, 1);
      chk("east_wall_literal", front_sensor, 1);
      step("east_bump", 1, 0);

      // Path to goal, sticky flag, then asynchronous reset
      do_reset();
      step("g_turn", 0, 1);
      for (int i = 0; i < 3; i++) step("g_east", 1, 0);
      for (int i = 0; i < 3; i++) step("g_rot", 0, 1);
      for (int i = 0; i < 3; i++) step("g_north", 1, 0);
      chk("goal_literal", at_goal, 1);
      step("g_rot_s1", 0, 1);
      step("g_rot_s2", 0, 1);
      step("g_leave", 1, 0);
      chk("goal_sticky", at_goal, 1);
      #1 rst_n = 0;
      #1;
      m_reset();
      check_all("async_rst");
      @(posedge clk);
      #1 rst_n = 1;

      // Randomized sensor-driven run with random map loading
      for (int n = 0; n < 250; n++) begin
         bit f, t, we;
         f  = front_sensor ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         t  = front_sensor ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
         we = ($urandom_range(0, 5) == 0);
         step("rand", f, t, we, $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom));
         chk("rand.no_x", 32'($isunknown({front_sensor, left_sensor, pos_x, pos_y,
                                          heading, bump, at_goal, step_count})), 0);
      end

      // Small instance: ignored out-of-range writes, then saturation
      do_reset();
      chk("s.reset_front", s_fs, 0);
      s_we = 1; s_x = 2'd3; s_y = 2'd0; s_walls = 4'hF;
      @(posedge clk); #1;
      s_x = 2'd0; s_y = 2'd3;
      @(posedge clk); #1;
      s_we = 0;
      chk("s.oor_ignored", s_fs, 0);
      $display("small: oor writes front_sensor=%0b", s_fs);
      s_we = 1; s_x = 2'd0; s_y = 2'd0; s_walls = 4'b0010;
      @(posedge clk); #1;
      s_we = 0;
      chk("s.valid_write", s_fs, 1);
      s_turn = 1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
      end
      s_turn = 0;
      chk("s.saturate", s_cnt, 7);
      chk("s.heading", s_hdg, 2);
      $display("small: count=%0d heading=%0d", s_cnt, s_hdg);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
